// File: rtl/booth_divider_seq_if.sv
// Start/done handshake and result bus for booth_divider_seq.
// The DUT connects through the slave modport and the requester through master.
interface booth_divider_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential signed restoring divider: one shift/trial-subtract step per cycle on
// the unsigned magnitudes, then a sign-fix cycle that registers the results.
module booth_divider_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    booth_divider_seq_if.slave     bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_dvd;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz_o;
    logic             r_ovf_o;

    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH:0]   w_ash;
    logic [WIDTH:0]   w_trial;
    logic             w_is_ovf;

    always_comb begin
        w_abs_dvd = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        w_abs_dvs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        w_is_ovf  = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
        // A stays below M, so its top bit is always 0 between steps; only the
        // shifted/trial values need the extra bit.
        w_ash     = {r_a, r_q[WIDTH-1]};
        w_trial   = w_ash - {1'b0, r_m};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = (bus.divisor == '0) ? S_FIX : S_RUN;
            S_RUN:  if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_dvd    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dz_o   <= 1'b0;
            r_ovf_o  <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a      <= '0;
                        r_q      <= w_abs_dvd;
                        r_m      <= w_abs_dvs;
                        r_dvd    <= bus.dividend;
                        r_cnt    <= CW'(WIDTH);
                        r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_sign_r <= bus.dividend[WIDTH-1];
                        r_dz     <= (bus.divisor == '0);
                        r_ovf    <= w_is_ovf;
                    end
                end
                S_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_a <= w_trial[WIDTH-1:0];
                        r_q <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_a <= w_ash[WIDTH-1:0];
                        r_q <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_quot  <= '1;
                        r_rem   <= r_dvd;
                        r_dz_o  <= 1'b1;
                        r_ovf_o <= 1'b0;
                    end else begin
                        r_quot  <= r_sign_q ? -r_q : r_q;
                        r_rem   <= r_sign_r ? -r_a : r_a;
                        r_dz_o  <= 1'b0;
                        r_ovf_o <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dz_o;
    assign bus.overflow    = r_ovf_o;
endmodule

// File: doc/booth_divider_seq.md
# booth_divider_seq

Sequential signed restoring divider: the division counterpart to the Booth multiplier datapath. Where the multiplier shifts its {Q, Qm1} pair right arithmetically, this block shifts its {A, Q} partial-remainder/quotient pair left, one bit per cycle, and does a trial subtraction on each step. It takes two WIDTH-bit two's-complement operands through a start/done handshake. It returns a quotient truncated toward zero and a remainder that carries the sign of the dividend, plus divide-by-zero and overflow flags.

## Interface
- WIDTH, 4, operand/result width in bits (two's complement); must be ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- start  input  1  request; accepted only in IDLE
- dividend  input  WIDTH  signed dividend; sampled on the accepting edge
- divisor  input  WIDTH  signed divisor; sampled on the accepting edge
- busy  output  1  high while an operation is in progress (RUN or FIX)
- done  output  1  single-cycle pulse; results valid from this cycle onward
- quotient  output  WIDTH  signed quotient; holds until the next done
- remainder  output  WIDTH  signed remainder; holds until the next done
- div_by_zero  output  1  divisor was 0 on the last completed operation
- overflow  output  1  the last completed operation was most-negative / −1

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1: latch |dividend| into Q (WIDTH bits, unsigned), |divisor| into M (WIDTH bits, unsigned), clear A (WIDTH+1 bits), and load count=WIDTH. Record sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - If divisor==0, go straight to FIX with the dz flag set.
  - Otherwise go to RUN.
- Magnitude of the most-negative value (e.g. 1000 → 8) fits the unsigned WIDTH-bit register.
- RUN, one step per cycle:
  - {A,Q} <= {A,Q} << 1.
  - Trial T = A_shifted − {0,M}.
  - If T ≥ 0: A <= T and Q[0] <= 1. Otherwise A is kept and Q[0] <= 0.
  - Decrement count. When count reaches 1 (last step), next state is FIX.
- FIX, one cycle, writes the output registers and then returns to IDLE:
  - quotient = sign_q ? −Q : Q (mod 2^WIDTH).
  - remainder = sign_r ? −A[WIDTH−1:0] : A[WIDTH−1:0].
  - overflow = 1 iff dividend was most-negative and divisor was −1. Quotient then wraps to the most-negative value and remainder = 0.
  - Divide by zero: quotient = all ones, remainder = original dividend, div_by_zero=1, overflow=0.
  - done=1 for exactly this one cycle.
- start while busy is ignored; operands are not re-sampled.
- start held high through done: a new operation is accepted on the first IDLE edge after done.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0. This also applies mid-operation and aborts it without any done.
- Let edge 0 be the edge where IDLE samples start=1.
- Normal divisor: busy=1 after edge 0. Edges 1..WIDTH run the RUN steps. Edge WIDTH+1 loads the results and sets done=1, busy=0. Latency is WIDTH+1 cycles (5 for WIDTH=4).
- Divisor 0: done=1 after edge 1 (latency 1).
- done deasserts on the following edge. Outputs and flags are stable from done until the next done or reset.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0, busy=0. Then 7/2 (0111/0010) → after 5 cycles done=1 for one cycle, quotient=0011, remainder=0001, flags 0.
- Signs: −7/2 → q=1101 (−3), r=1111 (−1). 7/−2 → q=1101, r=0001. −8/3 → q=1110 (−2), r=1110 (−2). Every case has latency 5.
- Boundaries:
  - −8/−1 → q=1000, r=0000, overflow=1.
  - −8/1 → q=1000, overflow=0.
  - 0/5 → q=0, r=0.
  - 3/7 → q=0, r=0011.
- Divide by zero: 5/0 → done one cycle after accept, q=1111, r=0101, div_by_zero=1. The next valid op clears div_by_zero at its done.
- Handshake: pulse start with 6/3. Re-pulse start with 1/1 during busy → result q=0010, r=0 and exactly one done. start held high continuously → back-to-back ops with one IDLE cycle between done and the next busy.
- Mid-op reset: start 7/2 and assert rst at edge 3 → no done, all outputs 0. Next 6/−4 → q=1111 (−1), r=0010.
